simd_shift_pipe: RTL

Parametrised, pipelined SIMD shift/rotate unit for the FX2 even pipe. It generalises the fixed halfword shift-left to a configurable element width and four shift modes. It carries a destination tag alongside each operation and supports valid/ready backpressure. One 128-bit operation is accepted per cycle, and results emerge after a fixed `STAGES`-cycle latency.

---
 rtl/simd_shift_pipe.sv | 71 +++++++
 1 files changed

// File: rtl/simd_shift_pipe.sv
// simd_shift_pipe: pipelined per-element SIMD shift/rotate with tag passthrough and valid/ready flow
module simd_shift_pipe #(
    parameter int EW     = 16,
    parameter int STAGES = 2,
    parameter int TAGW   = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [0:127]    ra,
    input  logic [0:127]    rb,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [0:127]    result,
    output logic [TAGW-1:0] out_tag
);
    localparam int N  = 128 / EW;
    localparam int CB = $clog2(EW);
    logic              adv;
    logic [0:127]      calc;
    logic [STAGES-1:0] v;
    logic [0:127]      d [STAGES];
    logic [TAGW-1:0]   t [STAGES];
    logic              unused_rb;
    assign unused_rb = ^rb;
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign out_valid = v[STAGES-1];
    assign result    = d[STAGES-1];
    assign out_tag   = t[STAGES-1];
    for (genvar k = 0; k < N; k++) begin : g_el
        logic [EW-1:0]        e;
        logic [EW-1:0]        r;
        logic signed [EW-1:0] a;
        logic [CB:0]          s;
        // one element: counts >= EW yield zero / sign fill through native shift semantics
        always_comb begin
            e = ra[EW*k +: EW];
            s = rb[EW*k+EW-1-CB +: CB+1];
            a = $signed(e) >>> s;
            r = op == 2'd0 ? e << s :
                op == 2'd1 ? (e << s[CB-1:0]) | (e >> (EW - int'(s[CB-1:0]))) :
                op == 2'd2 ? e >> s : a;
        end
        assign calc[EW*k +: EW] = r;
    end
    // stages advance together; data and tag reload only behind a valid op so outputs hold their last value
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            d <= '{default: '0};
            t <= '{default: '0};
        end else if (adv) begin
            v[0] <= in_valid;
            if (in_valid) begin
                d[0] <= calc;
                t[0] <= in_tag;
            end
            for (int i = 1; i < STAGES; i++) begin
                v[i] <= v[i-1];
                if (v[i-1]) begin
                    d[i] <= d[i-1];
                    t[i] <= t[i-1];
                end
            end
        end
    end
endmodule
